// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches the instruction at pc_out, waits for the
// datapath to finish it, then steps to pc+4 or to a taken branch/jump target.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 255,
    // Value retired takes on reset; left at 0 outside of wrap-around testing.
    parameter logic [31:0] RETIRED_INIT  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        take,
    input  logic        use_rs1,
    input  logic [31:0] immediate,
    input  logic [31:0] rs1_value,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        misalign_err,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  wait_q, wait_d;
    logic        misalign_q, misalign_d;
    logic        fetch_err_q, fetch_err_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] base;
    logic [31:0] sum;
    logic [31:0] target;
    logic [7:0]  wait_inc;

    // JALR clears bit 0 of its target; PC-relative targets keep every bit.
    assign base     = use_rs1 ? rs1_value : pc_q;
    assign sum      = base + immediate;
    assign target   = {sum[31:1], sum[0] & ~use_rs1};
    assign wait_inc = wait_q + 8'd1;
    assign pc_plus4 = pc_q + 32'd4;

    // Handshakes: a fetch completes on any cycle where imem_req and imem_ack
    // are both 1; an instruction retires on any cycle where instr_valid and
    // advance are both 1. Neither input has any effect outside those cycles.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        wait_d      = wait_q;
        misalign_d  = misalign_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                wait_d  = 8'd0;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end else if (wait_inc == TIMEOUT_LIM) begin
                    state_d     = ST_HALT;
                    wait_d      = wait_inc;
                    fetch_err_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    if (!take) begin
                        pc_d      = pc_plus4;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH;
                        wait_d    = 8'd0;
                    end else if (target[1:0] == 2'b00) begin
                        pc_d      = target;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH;
                        wait_d    = 8'd0;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            retired_q     <= RETIRED_INIT;
            wait_q        <= 8'd0;
            misalign_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            retired_q     <= retired_d;
            wait_q        <= wait_d;
            misalign_q    <= misalign_d;
            fetch_err_q   <= fetch_err_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instr_valid  = instr_valid_q;
    assign pc_out       = pc_q;
    assign retired      = retired_q;
    assign misalign_err = misalign_q;
    assign fetch_err    = fetch_err_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 255, maximum cycles waiting for imem_ack; legal range 1..255.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; equals pc_out.
REQ-007 imem_ack  input  1  fetch complete; sampled only while imem_req=1.
REQ-008 instr_valid  output  1  fetched instruction at pc_out is valid for the datapath.
REQ-009 advance  input  1  datapath finished the current instruction; request next PC.
REQ-010 take  input  1  branch/jump taken; qualified by advance.
REQ-011 use_rs1  input  1  target base is rs1_value (JALR); otherwise pc_out.
REQ-012 immediate  input  32  offset from the immediate generator.
REQ-013 rs1_value  input  32  register base for JALR.
REQ-014 pc_out  output  32  current PC.
REQ-015 pc_plus4  output  32  pc_out + 4, modulo 2^32, combinational.
REQ-016 retired  output  32  count of accepted advances.
REQ-017 misalign_err  output  1  sticky; taken target not word-aligned.
REQ-018 fetch_err  output  1  sticky; fetch timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-020 IDLE SHALL drive all request outputs low and go to FETCH unconditionally on the next cycle.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc_out; on imem_ack=1 the FSM SHALL go to EXEC.
REQ-022 In FETCH, a wait counter SHALL increment each cycle without ack; when it reaches FETCH_TIMEOUT without ack, the FSM SHALL go to HALT and set fetch_err.
REQ-023 The wait counter SHALL clear on every entry to FETCH.
REQ-024 instr_valid SHALL be 1 exactly while in EXEC; imem_req SHALL be 0 in EXEC, IDLE and HALT.
REQ-025 In EXEC with advance=0, PC and state SHALL hold indefinitely.
REQ-026 Target SHALL be (use_rs1 ? rs1_value : pc_out) + immediate, modulo 2^32; when use_rs1=1, bit 0 of the target SHALL be cleared.
REQ-027 In EXEC with advance=1 and take=0: pc_out SHALL be set to pc_plus4, retired SHALL increment, and the FSM SHALL go to FETCH.
REQ-028 In EXEC with advance=1, take=1 and target[1:0]=0: pc_out SHALL be set to the target, retired SHALL increment, and the FSM SHALL go to FETCH.
REQ-029 In EXEC with advance=1, take=1 and target[1:0]!=0: pc_out and retired SHALL hold, misalign_err SHALL set, and the FSM SHALL go to HALT.
REQ-030 take, use_rs1, immediate and rs1_value SHALL be ignored when advance=0 or when not in EXEC.
REQ-031 advance SHALL be ignored outside EXEC.
REQ-032 PC wrap-around: pc_out=32'hFFFF_FFFC with take=0 SHALL yield pc_out=0, with no error.
REQ-033 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-034 HALT SHALL persist until reset, with pc_out, retired and the error flags frozen.
REQ-035 imem_ack arriving in the same cycle the timeout is reached SHALL be honoured: the FSM goes to EXEC and fetch_err stays 0.

Reset
REQ-036 On reset=1 at a clock edge, from any state (including mid-FETCH), the FSM SHALL go to IDLE.
REQ-037 Reset values: pc_out=RESET_PC, retired=0, misalign_err=0, fetch_err=0, wait counter=0, imem_req=0, instr_valid=0.
REQ-038 Reset SHALL take priority over ack, advance and timeout in the same cycle.

Verification
REQ-039 Sequential flow: reset, ack one cycle after request, advance with take=0, three times -> imem_addr 0,4,8,C in successive FETCHes, retired=3.
REQ-040 Branch: pc_out=0x100, take=1, use_rs1=0, immediate=0xFFFF_FFF0 -> pc_out=0xF0, next fetch at 0xF0.
REQ-041 JALR: rs1_value=0x2001, immediate=0x4, use_rs1=1, take=1 -> pc_out=0x2004; with immediate=0x6 -> target 0x2006, misalign_err=1, HALT, pc_out holds 0x2001-era value.
REQ-042 Timeout: FETCH_TIMEOUT=4, ack never -> fetch_err=1 after 4 wait cycles; ack on the 4th cycle -> EXEC, no error.
REQ-043 Wrap: pc_out=0xFFFF_FFFC, take=0 -> pc_out=0; retired preloaded to 0xFFFF_FFFF -> 0.
REQ-044 Reset mid-FETCH with ack high in the same cycle -> IDLE, imem_req=0, pc_out=RESET_PC next cycle.
